load_store_unit: RTL and testbench

- CPU-side initiator for the shared single-port data memory. Owns the memory's address, write_data and write_enable pins and consumes its read_data.
- Accepts one load/store request at a time from the execute stage and returns one response.
- The memory supports only aligned word writes, so byte and halfword stores are done as read-modify-write sequences.
- Loads are extracted from the word and zero- or sign-extended.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject requests at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    // An illegal size is treated as a fault just like a misaligned address.
    function automatic logic misaligned(input size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends a load from a memory word, and merges a
// sub-word store lane into the old word for the read-modify-write path.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  size_t       size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_v;

    assign byte_v = word_i[{offset_i, 3'b000} +: 8];
    assign half_v = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = '0;
        sign_v  = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                sign_v  = ~unsigned_i & byte_v[7];
                rdata_o = {{24{sign_v}}, byte_v};
            end
            SZ_HALF: begin
                sign_v  = ~unsigned_i & half_v[15];
                rdata_o = {{16{sign_v}}, half_v};
            end
            SZ_WORD: rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        unique case (size_i)
            SZ_BYTE: merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            SZ_HALF: merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_WORD: merged_o = wdata_i;
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit driving a synchronous single-port word memory; sub-word
// stores are done as read-modify-write through ISSUE/CAPTURE/WRITE.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    size_t             size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

    size_t             req_size_t;
    logic              accept;
    logic              req_fault;
    logic [DATA_W-1:0] ext_rdata;
    logic [DATA_W-1:0] merged_word;

    assign req_size_t = size_t'(req_size);
    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign req_fault  = misaligned(req_size_t, req_addr[1:0]);

    lsu_align u_align (
        .word_i     (mem_read_data),
        .wdata_i    (wdata_q),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rdata_o    (ext_rdata),
        .merged_o   (merged_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (req_we && req_size_t == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE:   state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        size_d           = size_q;
        we_d             = we_q;
        uns_d            = uns_q;
        resp_rdata_d     = resp_rdata_q;
        resp_fault_d     = resp_fault_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_valid_d     = (state_d == ST_RESP);

        if (accept) begin
            addr_d       = req_addr;
            wdata_d      = req_wdata;
            size_d       = req_size_t;
            we_d         = req_we;
            uns_d        = req_unsigned;
            resp_rdata_d = '0;
            resp_fault_d = req_fault;
            if (!req_fault && req_we && req_size_t == SZ_WORD) begin
                mem_write_data_d = req_wdata;
            end
        end

        // mem_read_data carries the old word only while in CAPTURE.
        if (state_q == ST_CAPTURE) begin
            if (we_q) begin
                mem_write_data_d = merged_word;
            end else begin
                resp_rdata_d = ext_rdata;
            end
        end

        if (state_d == ST_ISSUE || state_d == ST_WRITE) begin
            mem_address_d = {addr_d[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            size_q           <= SZ_BYTE;
            we_q             <= 1'b0;
            uns_q            <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_fault_q     <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            size_q           <= size_d;
            we_q             <= we_d;
            uns_q            <= uns_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_fault_q     <= resp_fault_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // Gated by reset so an abort during WRITE never reaches the memory.
    assign mem_write_enable = (state_q == ST_WRITE) && !reset;

    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_fault     = resp_fault_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset abort, held-valid streaming and
// randomized traffic checked against a request-level memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    logic        mem_clr;
    logic [31:0] ref_mem [64];

    int n_cmp;
    int n_fail;

    load_store_unit #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory decoding address bits [7:2].
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_write_enable) begin
            mem[mem_address[7:2]] <= mem_write_data;
        end
        mem_read_data <= mem[mem_address[7:2]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_fail, n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Request-level reference: applies the access to ref_mem byte by byte.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic fault,
                                  output int lat);
        int off;
        int idx;
        int nbytes;
        off   = int'(addr[1:0]);
        idx   = int'(addr[7:2]);
        rdata = 32'h0;
        fault = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && off != 0);
        if (fault) begin
            lat = 1;
            return;
        end
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (we) begin
            for (int b = 0; b < nbytes; b++) ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
            lat = (nbytes == 4) ? 2 : 4;
        end else begin
            for (int b = 0; b < nbytes; b++) rdata[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
            if (!uns && nbytes < 4 && rdata[8*nbytes-1]) begin
                rdata = rdata | ~((32'h1 << (8*nbytes)) - 32'h1);
            end
            lat = 3;
        end
    endfunction

    // Issue one request from idle (called at a negedge) and check its full response.
    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
        logic [31:0] addr_before;
        int          lat;
        int          wes;
        bit          seen;
        addr_before  = mem_address;
        check({name, "/ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        lat  = 1;
        wes  = 0;
        seen = 0;
        while (lat <= 8) begin
            wes += int'(mem_write_enable);
            if (resp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (seen) begin
            check({name, "/rdata"}, resp_rdata, exp_rdata);
            check({name, "/fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
        end
        check({name, "/we_pulses"}, 32'(wes), (we && !exp_fault) ? 32'd1 : 32'd0);
        if (exp_fault) check({name, "/addr_hold"}, mem_address, addr_before);
        else check({name, "/mem_addr"}, mem_address, {addr[31:2], 2'b00});
        @(negedge clk);
        check({name, "/valid_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] m_rdata;
        logic        m_fault;
        int          m_lat;
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        logic        r_we;
        logic        r_uns;
        logic [31:0] r_wdata;
        exp_t        expq[$];
        exp_t        e;
        bit          advance;
        bit          prev_valid;
        int          idx;
        int          got;
        int          wait_cnt;

        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        vecs[0]  = '{"sw_10",       1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[1]  = '{"lw_10",       1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{"sw_10_init",  1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2};
        vecs[3]  = '{"sb_13",       1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, 32'h0,        1'b0, 4};
        vecs[4]  = '{"lw_10_rmw",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0, 3};
        vecs[5]  = '{"lb_13_s",     1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[6]  = '{"lbu_13",      1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 3};
        vecs[7]  = '{"lb_10_s",     1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000044, 1'b0, 3};
        vecs[8]  = '{"sw_20_zero",  1'b1, 2'd2, 1'b0, 32'h20, 32'h0,        32'h0,        1'b0, 2};
        vecs[9]  = '{"sh_22",       1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h0,        1'b0, 4};
        vecs[10] = '{"lw_20",       1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'hABCD0000, 1'b0, 3};
        vecs[11] = '{"lh_22_s",     1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFFABCD, 1'b0, 3};
        vecs[12] = '{"lhu_22",      1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h0000ABCD, 1'b0, 3};
        vecs[13] = '{"lw_11_fault", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1};
        vecs[14] = '{"sh_21_fault", 1'b1, 2'd1, 1'b0, 32'h21, 32'h5555,     32'h0,        1'b1, 1};
        vecs[15] = '{"ill_20",      1'b1, 2'd3, 1'b0, 32'h20, 32'h77,       32'h0,        1'b1, 1};
        vecs[16] = '{"lh_20_keep",  1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        32'h00000000, 1'b0, 3};
        vecs[17] = '{"lbu_11",      1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h00000033, 1'b0, 3};

        reset        = 1'b1;
        mem_clr      = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("rst/resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst/resp_rdata", resp_rdata, 32'd0);
        check("rst/resp_fault", {31'b0, resp_fault}, 32'd0);
        check("rst/mem_address", mem_address, 32'd0);
        check("rst/mem_wdata", mem_write_data, 32'd0);
        check("rst/mem_we", {31'b0, mem_write_enable}, 32'd0);
        reset   = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        check("rst/req_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  m_rdata, m_fault, m_lat);
            do_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat);
        end
        check("mem_10", mem[4], 32'h80223344);
        check("mem_20", mem[8], 32'hABCD0000);

        // Reset asserted in the WRITE cycle of a byte store must abort it cleanly.
        model(1'b1, 2'd2, 1'b0, 32'h30, 32'h55667788, m_rdata, m_fault, m_lat);
        do_req("sw_30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h55667788, 32'h0, 1'b0, 2);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h31;
        req_wdata = 32'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        wait_cnt  = 0;
        while (!mem_write_enable && wait_cnt < 8) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("abort/reached_write", {31'b0, mem_write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort/we_gated", {31'b0, mem_write_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort/no_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("abort/no_resp2", {31'b0, resp_valid}, 32'd0);
        check("abort/ready", {31'b0, req_ready}, 32'd1);
        check("abort/mem_kept", mem[12], 32'h55667788);

        // Held req_valid streaming: responses in order, one pulse each.
        idx        = 0;
        got        = 0;
        advance    = 0;
        prev_valid = 0;
        req_valid  = 1'b1;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h35; req_wdata = 32'hC3;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
            if (advance) begin
                idx++;
                case (idx)
                    1: begin req_we = 1'b0; req_size = 2'd2; req_addr = 32'h34; end
                    2: begin req_we = 1'b0; req_size = 2'd1; req_addr = 32'h33; end
                    3: begin req_we = 1'b1; req_size = 2'd2; req_addr = 32'h38;
                             req_wdata = 32'h0BADF00D; end
                    4: begin req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
                             req_addr = 32'h3B; end
                    5: begin req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b1;
                             req_addr = 32'h3A; end
                    default: req_valid = 1'b0;
                endcase
                advance = 0;
            end
            if (resp_valid) begin
                check("stream/single_pulse", {31'b0, prev_valid}, 32'd0);
                if (expq.size() == 0) begin
                    check("stream/unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("stream/rdata", resp_rdata, e.rdata);
                    check("stream/fault", {31'b0, resp_fault}, {31'b0, e.fault});
                end
                got++;
            end
            prev_valid = resp_valid;
            if (req_valid && req_ready) begin
                model(req_we, req_size, req_unsigned, req_addr, req_wdata, e.rdata, e.fault,
                      m_lat);
                expq.push_back(e);
                advance = 1;
            end
            if (got < 6) @(negedge clk);
        end
        check("stream/count", 32'(got), 32'd6);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            r_we    = 1'($urandom);
            r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_uns   = 1'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r_addr[1:0] = (r_size == 2'd2) ? 2'b00 : (r_size == 2'd1) ? {r_addr[1], 1'b0}
                                                                          : r_addr[1:0];
            end
            model(r_we, r_size, r_uns, r_addr, r_wdata, m_rdata, m_fault, m_lat);
            do_req("rand", r_we, r_size, r_uns, r_addr, r_wdata, m_rdata, m_fault, m_lat);
        end

        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
